// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - nibble-serial WIDTH-bit adder sequencer around an external 4-bit RCA stage
// Define RCA_SEQ_OVF_EN to add the registered signed-overflow output result_ovf.
module rca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
`ifdef RCA_SEQ_OVF_EN
  output logic             result_ovf,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             accept;
  logic             last;
  logic             in_run;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign in_run   = (state == ST_RUN);
  assign last     = (idx == LAST_IDX);

  // Nibble select by compare loop keeps the mux clean for non-power-of-two NIBBLES.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  assign add_a   = in_run ? a_nib : 4'h0;
  assign add_b   = in_run ? b_nib : 4'h0;
  assign add_cin = in_run ? carry_reg : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      carry_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      result      <= '0;
      result_cout <= 1'b0;
      out_valid   <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      result_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
            result    <= '0;
`ifdef RCA_SEQ_OVF_EN
            result_ovf <= 1'b0;
`endif
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDXW'(i)) begin
              result[4*i +: 4] <= add_sum;
            end
          end
          carry_reg <= add_cout;
          if (last) begin
            result_cout <= add_cout;
`ifdef RCA_SEQ_OVF_EN
            result_ovf  <= (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
`endif
            out_valid   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - randomized self-checking bench for rca_seq_adder (WIDTH=16 and WIDTH=4)
module tb_rca_seq_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        w16_in_valid, w16_in_ready, w16_op_cin, w16_out_valid, w16_out_ready, w16_result_cout;
  logic [15:0] w16_op_a, w16_op_b, w16_result;
  logic [3:0]  w16_add_a, w16_add_b, w16_add_sum;
  logic        w16_add_cin, w16_add_cout;

  logic        w4_in_valid, w4_in_ready, w4_op_cin, w4_out_valid, w4_out_ready, w4_result_cout;
  logic [3:0]  w4_op_a, w4_op_b, w4_result;
  logic [3:0]  w4_add_a, w4_add_b, w4_add_sum;
  logic        w4_add_cin, w4_add_cout;

`ifdef RCA_SEQ_OVF_EN
  logic w16_result_ovf, w4_result_ovf;
`endif

  // Behavioural 4-bit adder stage for each instance.
  assign {w16_add_cout, w16_add_sum} = 5'(w16_add_a) + 5'(w16_add_b) + 5'(w16_add_cin);
  assign {w4_add_cout, w4_add_sum}   = 5'(w4_add_a) + 5'(w4_add_b) + 5'(w4_add_cin);

  rca_seq_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready),
    .op_a(w16_op_a), .op_b(w16_op_b), .op_cin(w16_op_cin),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready),
    .result(w16_result), .result_cout(w16_result_cout),
`ifdef RCA_SEQ_OVF_EN
    .result_ovf(w16_result_ovf),
`endif
    .add_a(w16_add_a), .add_b(w16_add_b), .add_cin(w16_add_cin),
    .add_sum(w16_add_sum), .add_cout(w16_add_cout)
  );

  rca_seq_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .op_a(w4_op_a), .op_b(w4_op_b), .op_cin(w4_op_cin),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready),
    .result(w4_result), .result_cout(w4_result_cout),
`ifdef RCA_SEQ_OVF_EN
    .result_ovf(w4_result_ovf),
`endif
    .add_a(w4_add_a), .add_b(w4_add_b), .add_cin(w4_add_cin),
    .add_sum(w4_add_sum), .add_cout(w4_add_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin, input int hold);
    logic [16:0] full;
    logic [16:0] mask;
    logic [16:0] part;
    logic [15:0] held;
    int waited;
    full = {1'b0, a} + {1'b0, b} + 17'(cin);
    waited = 0;
    while (!w16_in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("w16_idle_ready", 32'(w16_in_ready), 32'd1);
    w16_op_a = a;
    w16_op_b = b;
    w16_op_cin = cin;
    w16_in_valid = 1'b1;
    tick();
    w16_in_valid = 1'b0;
    w16_op_a = 16'($urandom);
    w16_op_b = 16'($urandom);
    check("w16_ready_drop", 32'(w16_in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      // Carry into nibble k is bit 4k of the sum of the lower 4k bits.
      mask = (17'h1 << (4 * k)) - 17'h1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 17'(cin);
      check("w16_run_a", 32'(w16_add_a), 32'((a >> (4 * k)) & 16'hF));
      check("w16_run_b", 32'(w16_add_b), 32'((b >> (4 * k)) & 16'hF));
      check("w16_run_cin", 32'(w16_add_cin), 32'((part >> (4 * k)) & 17'h1));
      check("w16_run_valid", 32'(w16_out_valid), 32'd0);
      tick();
    end
    check("w16_out_valid", 32'(w16_out_valid), 32'd1);
    check("w16_result", 32'(w16_result), 32'(full[15:0]));
    check("w16_cout", 32'(w16_result_cout), 32'(full[16]));
    check("w16_done_add_a", 32'(w16_add_a), 32'd0);
    check("w16_done_add_cin", 32'(w16_add_cin), 32'd0);
`ifdef RCA_SEQ_OVF_EN
    check("w16_ovf", 32'(w16_result_ovf), 32'((a[15] == b[15]) && (full[15] != a[15])));
`endif
    held = w16_result;
    for (int h = 0; h < hold; h++) begin
      w16_in_valid = 1'b1;
      w16_op_a = 16'($urandom);
      w16_op_b = 16'($urandom);
      w16_out_ready = 1'b0;
      tick();
      check("w16_hold_result", 32'(w16_result), 32'(held));
      check("w16_hold_ready", 32'(w16_in_ready), 32'd0);
      check("w16_hold_valid", 32'(w16_out_valid), 32'd1);
    end
    w16_in_valid = 1'b0;
    w16_out_ready = 1'b1;
    tick();
    w16_out_ready = 1'b0;
    check("w16_release_valid", 32'(w16_out_valid), 32'd0);
    check("w16_release_ready", 32'(w16_in_ready), 32'd1);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] full;
    full = 5'(a) + 5'(b) + 5'(cin);
    check("w4_idle_ready", 32'(w4_in_ready), 32'd1);
    w4_op_a = a;
    w4_op_b = b;
    w4_op_cin = cin;
    w4_in_valid = 1'b1;
    tick();
    w4_in_valid = 1'b0;
    check("w4_run_a", 32'(w4_add_a), 32'(a));
    check("w4_run_cin", 32'(w4_add_cin), 32'(cin));
    tick();
    check("w4_out_valid", 32'(w4_out_valid), 32'd1);
    check("w4_result", 32'(w4_result), 32'(full[3:0]));
    check("w4_cout", 32'(w4_result_cout), 32'(full[4]));
    w4_out_ready = 1'b1;
    tick();
    w4_out_ready = 1'b0;
    check("w4_release_ready", 32'(w4_in_ready), 32'd1);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1;
    w16_in_valid = 1'b0; w16_out_ready = 1'b0; w16_op_a = '0; w16_op_b = '0; w16_op_cin = 1'b0;
    w4_in_valid = 1'b0;  w4_out_ready = 1'b0;  w4_op_a = '0;  w4_op_b = '0;  w4_op_cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(w16_in_ready), 32'd1);
    check("rst_out_valid", 32'(w16_out_valid), 32'd0);
    check("rst_result", 32'(w16_result), 32'd0);
    check("rst_cout", 32'(w16_result_cout), 32'd0);
    check("rst_add_a", 32'(w16_add_a), 32'd0);
`ifdef RCA_SEQ_OVF_EN
    check("rst_ovf", 32'(w16_result_ovf), 32'd0);
`endif

    run16(16'h00FF, 16'h0001, 1'b0, 0);
    run16(16'hFFFF, 16'h0000, 1'b1, 0);
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1);
    run16(16'h0F0F, 16'hF0F0, 1'b0, 3);
    run16(16'h1234, 16'h4321, 1'b0, 0);
`ifdef RCA_SEQ_OVF_EN
    run16(16'h7FFF, 16'h0001, 1'b0, 0);
    run16(16'h8000, 16'h8000, 1'b0, 0);
    run16(16'h0003, 16'h0004, 1'b0, 0);
`endif

    // Reset on the second RUN cycle discards the partial operation.
    w16_op_a = 16'hAAAA;
    w16_op_b = 16'h5555;
    w16_op_cin = 1'b0;
    w16_in_valid = 1'b1;
    w16_out_ready = 1'b1;
    tick();
    w16_in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(w16_out_valid), 32'd0);
    check("midrst_result", 32'(w16_result), 32'd0);
    check("midrst_ready", 32'(w16_in_ready), 32'd1);
    check("midrst_cout", 32'(w16_result_cout), 32'd0);
    seen_valid = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (w16_out_valid) seen_valid++;
    end
    w16_out_ready = 1'b0;
    check("midrst_no_result", 32'(seen_valid), 32'd0);

    for (int n = 0; n < 16; n++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    run4(4'h9, 4'h8, 1'b0);
    run4(4'hF, 4'h0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
